// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
//   Two-entry registered pipeline stage with a valid/ready handshake on both
//   sides. It replaces a bare enabled data register between pipeline stages.
//   It absorbs one extra word while downstream stalls, so a stall never drops
//   or duplicates a word. in_ready comes straight from a flop, so no
//   combinational path runs from out_ready back to in_ready.
//
//   State table
//     state | meaning
//     EMPTY | main and skid entries both empty
//     ONE   | main entry valid, skid entry empty
//     TWO   | main and skid entries valid, upstream stalled
//
// Ports
//   clk        in   1      clock; all state updates on posedge
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous flush; drops all held entries
//   in_valid   in   1      upstream presents in_data
//   in_ready   out  1      stage can accept (registered)
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      out_data holds a valid entry
//   out_ready  in   1      downstream accepts
//   out_data   out  WIDTH  payload presented downstream
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic             w_acc;
    logic             w_pop;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    assign w_acc = in_valid & r_in_ready;
    assign w_pop = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            // Flush wins over both handshakes. The data registers keep stale
            // contents; only the valids clear.
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_acc && w_pop) begin
                        w_load_main_in = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt = TWO;
                        w_load_skid = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move the state.
                    if (w_pop) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            // The handshake flags are registered copies of the next state.
            // This keeps in_ready and out_valid free of combinational paths.
            r_out_valid <= (w_state_nxt != EMPTY);
            r_in_ready  <= (w_state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

`ifndef SYNTHESIS
    a_valid_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (r_out_valid && !out_ready && !flush) |=> r_out_valid)
        else $error("out_valid fell without pop, flush or reset");

    a_ready_two : assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == TWO) |-> !r_in_ready)
        else $error("in_ready high while both entries are full");
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
module tb_pipe_skid_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_q[$];
    int          mdl_pops = 0;
    int          dut_pops = 0;
    bit          seen_cafe = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_buffer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Two-deep FIFO model: ready while fewer than two words are held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_q.delete();
        end else if (flush) begin
            mdl_q.delete();
        end else begin
            bit m_acc;
            bit m_pop;
            m_acc = in_valid && (mdl_q.size() < 2);
            m_pop = out_ready && (mdl_q.size() > 0);
            if (m_pop) begin
                void'(mdl_q.pop_front());
                mdl_pops++;
            end
            if (m_acc) mdl_q.push_back(in_data);
        end
    end

    always @(posedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) dut_pops++;
    end

    always @(negedge clk) begin
        if (out_valid && out_data == 32'hCAFEF00D) seen_cafe = 1'b1;
        if (!rst_n) begin
            check("rst_out_valid", {31'b0, out_valid}, 32'd0);
            check("rst_in_ready", {31'b0, in_ready}, 32'd1);
            check("rst_out_data", out_data, 32'h0);
        end else begin
            check("cmp_out_valid", {31'b0, out_valid}, {31'b0, mdl_q.size() > 0});
            check("cmp_in_ready", {31'b0, in_ready}, {31'b0, mdl_q.size() < 2});
            if (out_valid && mdl_q.size() > 0)
                check("cmp_out_data", out_data, mdl_q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        // T1 reset
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t1_out_valid", {31'b0, out_valid}, 32'd0);
        check("t1_in_ready", {31'b0, in_ready}, 32'd1);
        check("t1_out_data", out_data, 32'h0);
        rst_n = 1'b1;

        // T2 pass-through
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            step();
            check("t2_out_valid", {31'b0, out_valid}, 32'd1);
            check("t2_out_data", out_data, i);
            check("t2_in_ready", {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("t2_drained", {31'b0, out_valid}, 32'd0);

        // T3 backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5A5A5;
        step();
        check("t3_ready_one", {31'b0, in_ready}, 32'd1);
        check("t3_data_one", out_data, 32'hA5A5A5A5);
        in_data = 32'h5A5A5A5A;
        step();
        check("t3_ready_two", {31'b0, in_ready}, 32'd0);
        check("t3_data_held", out_data, 32'hA5A5A5A5);

        // T4 full hold: DEADBEEF offered while full
        in_data = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_ready", {31'b0, in_ready}, 32'd0);
            check("t4_data", out_data, 32'hA5A5A5A5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("t3_drain_valid", {31'b0, out_valid}, 32'd1);
        check("t3_drain_data", out_data, 32'h5A5A5A5A);
        check("t3_drain_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("t3_empty", {31'b0, out_valid}, 32'd0);

        // T5 flush in state TWO with a same-cycle input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11111111;
        step();
        in_data = 32'h22222222;
        step();
        check("t5_full", {31'b0, in_ready}, 32'd0);
        flush   = 1'b1;
        in_data = 32'hCAFEF00D;
        step();
        check("t5_valid", {31'b0, out_valid}, 32'd0);
        check("t5_ready", {31'b0, in_ready}, 32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("t5_still_empty", {31'b0, out_valid}, 32'd0);

        // T6 async reset between edges while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h33333333;
        step();
        in_data = 32'h44444444;
        step();
        in_valid = 1'b0;
        check("t6_full", {31'b0, in_ready}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'b0, out_valid}, 32'd0);
        check("t6_ready", {31'b0, in_ready}, 32'd1);
        check("t6_data", out_data, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // T7 random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = 32'h10000000 + i;
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("t7_pop_count", dut_pops, mdl_pops);
        check("t7_drained", {31'b0, out_valid}, 32'd0);
        check("t5_cafe_never_out", {31'b0, seen_cafe}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
